// File: rtl/memory_stage_if.sv
// Bus bundle for the memory stage: execute-side request, data-memory port
// and writeback-side bundle, all in one interface.
//   slave  : the memory stage itself (consumes ex_*, drives dmem_* and wb_*)
//   master : the surroundings (execute, data memory, writeback)
interface memory_stage_if #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 4
);
  // execute -> stage
  logic              ex_valid;
  logic              ex_ready;
  logic [31:0]       ex_alu_result;
  logic [31:0]       ex_store_data;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_wb_en;
  logic              ex_is_load;
  logic              ex_is_store;
  logic              ex_byte;
  // stage <-> data memory
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_be;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;
  // stage -> writeback
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_data;
  logic [REG_W-1:0]  wb_rd;
  logic              wb_wb_en;
  logic              wb_mem_err;

  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_wb_en,
           ex_is_load, ex_is_store, ex_byte, dmem_ack, dmem_rdata, wb_ready,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_data, wb_rd, wb_wb_en, wb_mem_err
  );

  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_wb_en,
           ex_is_load, ex_is_store, ex_byte, dmem_ack, dmem_rdata, wb_ready,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_data, wb_rd, wb_wb_en, wb_mem_err
  );
endinterface

// File: rtl/memory_stage.sv
// Memory-access stage between execute and writeback.
// Accepts one instruction per ex_valid/ex_ready handshake, runs loads and
// stores (word or byte) on the dmem req/ack port, passes ALU-only results
// straight through, and presents a registered {data, rd, wb_en, mem_err}
// bundle to writeback over wb_valid/wb_ready.
// Ports: clk, rst (async, active high) plus the memory_stage_if slave view.
// ADDR_W must not exceed 32 (address comes from the 32-bit ALU result).
module memory_stage #(
  parameter int ADDR_W      = 32,
  parameter int REG_W       = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  memory_stage_if.slave  bus
);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              accept, in_acc;

  // instruction fields captured on accept
  logic [31:0]       l_alu, l_sdata;
  logic [REG_W-1:0]  l_rd;
  logic              l_wb_en, l_load, l_byte;

  // writeback output register
  logic              wb_valid;
  logic [31:0]       wb_data;
  logic [REG_W-1:0]  wb_rd;
  logic              wb_wb_en, wb_mem_err;

  logic              wb_load;
  logic [31:0]       wb_data_nxt, rot;
  logic [REG_W-1:0]  wb_rd_nxt;
  logic              wb_en_nxt, wb_err_nxt;

  assign in_acc = (state == ACCESS);
  // rst term keeps ex_ready low while reset is held
  assign bus.ex_ready = !rst && (state == IDLE) && (!wb_valid || bus.wb_ready);
  assign accept = bus.ex_valid && bus.ex_ready;

  // Word loads rotate right by the byte offset; byte loads take lane 0 of
  // the rotated word, which is the addressed lane.
  assign rot = 32'({bus.dmem_rdata, bus.dmem_rdata} >> {l_alu[1:0], 3'b000});

  // Memory port is driven only in ACCESS, so reset or completion drops it at once.
  assign bus.dmem_req   = in_acc;
  assign bus.dmem_we    = in_acc && !l_load;
  assign bus.dmem_addr  = in_acc ? {l_alu[ADDR_W-1:2], 2'b00} : '0;
  assign bus.dmem_wdata = !in_acc ? '0 : l_byte ? {4{l_sdata[7:0]}} : l_sdata;
  assign bus.dmem_be    = (!in_acc || l_load) ? 4'h0 :
                          l_byte ? (4'b0001 << l_alu[1:0]) : 4'hF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    wb_load     = 1'b0;
    wb_data_nxt = '0;
    wb_rd_nxt   = l_rd;
    wb_en_nxt   = 1'b0;
    wb_err_nxt  = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (bus.ex_is_load || bus.ex_is_store) begin
          state_nxt = ACCESS;
        end else begin
          wb_load     = 1'b1;
          wb_data_nxt = bus.ex_alu_result;
          wb_rd_nxt   = bus.ex_rd;
          wb_en_nxt   = bus.ex_wb_en;
        end
      end
      ACCESS: begin
        // ack wins over timeout when both land in the same cycle
        if (bus.dmem_ack) begin
          state_nxt   = IDLE;
          wb_load     = 1'b1;
          wb_data_nxt = !l_load ? l_alu : l_byte ? {24'h0, rot[7:0]} : rot;
          wb_en_nxt   = l_load && l_wb_en;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_nxt   = IDLE;
          wb_load     = 1'b1;
          wb_err_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter sits at zero outside ACCESS, so it is clear on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (!in_acc)        cnt <= '0;
    else if (!bus.dmem_ack)  cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_alu   <= '0;
      l_sdata <= '0;
      l_rd    <= '0;
      l_wb_en <= 1'b0;
      l_load  <= 1'b0;
      l_byte  <= 1'b0;
    end else if (accept) begin
      l_alu   <= bus.ex_alu_result;
      l_sdata <= bus.ex_store_data;
      l_rd    <= bus.ex_rd;
      l_wb_en <= bus.ex_wb_en;
      l_load  <= bus.ex_is_load;
      l_byte  <= bus.ex_byte;
    end
  end

  // A new bundle may load in the same cycle the old one is consumed;
  // otherwise the bundle holds until wb_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      wb_wb_en   <= 1'b0;
      wb_mem_err <= 1'b0;
    end else if (wb_load) begin
      wb_valid   <= 1'b1;
      wb_data    <= wb_data_nxt;
      wb_rd      <= wb_rd_nxt;
      wb_wb_en   <= wb_en_nxt;
      wb_mem_err <= wb_err_nxt;
    end else if (bus.wb_ready) begin
      wb_valid   <= 1'b0;
    end
  end

  assign bus.wb_valid   = wb_valid;
  assign bus.wb_data    = wb_data;
  assign bus.wb_rd      = wb_rd;
  assign bus.wb_wb_en   = wb_wb_en;
  assign bus.wb_mem_err = wb_mem_err;
endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_stage_if #(.ADDR_W(32), .REG_W(4)) bus ();
  memory_stage #(.ADDR_W(32), .REG_W(4), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        wben;
    logic        err;
  } bundle_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: what writeback should receive for one instruction.
  function automatic bundle_t model(input logic [31:0] alu, input logic wben,
                                    input logic ld, input logic st, input logic byt,
                                    input logic [31:0] rdata, input logic timed_out);
    bundle_t b;
    logic [1:0] off;
    off = alu[1:0];
    b.data = alu; b.wben = wben; b.err = 1'b0;
    if (timed_out) begin
      b.data = 32'h0; b.wben = 1'b0; b.err = 1'b1;
    end else if (st) begin
      b.wben = 1'b0;
    end else if (ld) begin
      if (byt) b.data = {24'h0, rdata[8*off +: 8]};
      else for (int i = 0; i < 4; i++) b.data[8*i +: 8] = rdata[8*((i + off) % 4) +: 8];
    end
    return b;
  endfunction

  // Issue one instruction; for memory ops, ack in ACCESS cycle 'delay'
  // (negative or >= TO means never ack).
  task automatic run_op(input logic [31:0] alu, input logic [31:0] sd, input logic [3:0] rd,
                        input logic wben, input logic ld, input logic st, input logic byt,
                        input int delay, input logic [31:0] rdata);
    bundle_t e;
    logic to;
    logic [3:0] ebe;
    bus.ex_valid = 1'b1; bus.ex_alu_result = alu; bus.ex_store_data = sd;
    bus.ex_rd = rd; bus.ex_wb_en = wben; bus.ex_is_load = ld;
    bus.ex_is_store = st; bus.ex_byte = byt;
    #1 chk("ex_ready_idle", {31'h0, bus.ex_ready}, 32'h1);
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    to = 1'b0;
    if (ld || st) begin
      ebe = !st ? 4'h0 : byt ? (4'b0001 << alu[1:0]) : 4'hF;
      to = (delay < 0 || delay >= TO);
      for (int k = 0; k < TO; k++) begin
        bus.dmem_ack = (k == delay); bus.dmem_rdata = rdata;
        @(negedge clk);
        chk("req_hi", {31'h0, bus.dmem_req}, 32'h1);
        chk("addr", bus.dmem_addr, {alu[31:2], 2'b00});
        chk("we", {31'h0, bus.dmem_we}, {31'h0, st});
        chk("be", {28'h0, bus.dmem_be}, {28'h0, ebe});
        if (st) chk("wdata", bus.dmem_wdata, byt ? {4{sd[7:0]}} : sd);
        chk("ex_ready_busy", {31'h0, bus.ex_ready}, 32'h0);
        @(posedge clk); #1 bus.dmem_ack = 1'b0;
        if (k == delay) break;
      end
    end
    e = model(alu, wben, ld, st, byt, rdata, to);
    @(negedge clk);
    chk("req_lo", {31'h0, bus.dmem_req}, 32'h0);
    chk("wb_valid", {31'h0, bus.wb_valid}, 32'h1);
    chk("wb_data", bus.wb_data, e.data);
    if (!to) chk("wb_rd", {28'h0, bus.wb_rd}, {28'h0, rd});
    chk("wb_wb_en", {31'h0, bus.wb_wb_en}, {31'h0, e.wben});
    chk("wb_mem_err", {31'h0, bus.wb_mem_err}, {31'h0, e.err});
  endtask

  initial begin
    int d;
    logic ld, st;
    bus.ex_valid = 1'b1; bus.ex_alu_result = 32'h1234_5678; bus.ex_store_data = 32'h0;
    bus.ex_rd = 4'd3; bus.ex_wb_en = 1'b1; bus.ex_is_load = 1'b0; bus.ex_is_store = 1'b0;
    bus.ex_byte = 1'b0; bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0; bus.wb_ready = 1'b1;

    // reset with ex_valid held high: everything quiet
    #12;
    chk("rst_ex_ready", {31'h0, bus.ex_ready}, 32'h0);
    chk("rst_req", {31'h0, bus.dmem_req}, 32'h0);
    chk("rst_we", {31'h0, bus.dmem_we}, 32'h0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_wdata", bus.dmem_wdata, 32'h0);
    chk("rst_be", {28'h0, bus.dmem_be}, 32'h0);
    chk("rst_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
    chk("rst_wb_data", bus.wb_data, 32'h0);
    chk("rst_wb_rd", {28'h0, bus.wb_rd}, 32'h0);
    chk("rst_wb_en", {31'h0, bus.wb_wb_en}, 32'h0);
    chk("rst_wb_err", {31'h0, bus.wb_mem_err}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // first accept right after deassert, then back-to-back ALU ops
    for (int i = 0; i < 5; i++) run_op(32'h1234_5678, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0);

    // LDRB lane 3, ack on fourth ACCESS cycle
    run_op(32'h0000_1003, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 3, 32'hAABB_CCDD);
    chk("ldrb_value", bus.wb_data, 32'h0000_00AA);
    // STRB lane 1, then LDR rotated by two bytes
    run_op(32'h0000_2001, 32'h0000_00EE, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h0);
    run_op(32'h0000_2002, 32'h0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'h1122_3344);
    chk("ldr_value", bus.wb_data, 32'h3344_1122);

    // backpressure: bundle frozen, next op held off until wb_ready
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    bus.ex_valid = 1'b1; bus.ex_alu_result = 32'hCAFE_0001; bus.ex_rd = 4'd5;
    bus.ex_wb_en = 1'b1; bus.ex_is_load = 1'b0; bus.ex_is_store = 1'b0;
    @(posedge clk); #1;
    bus.ex_alu_result = 32'hCAFE_0002; bus.ex_rd = 4'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'h0, bus.wb_valid}, 32'h1);
      chk("bp_data", bus.wb_data, 32'hCAFE_0001);
      chk("bp_rd", {28'h0, bus.wb_rd}, 32'h5);
      chk("bp_ex_ready", {31'h0, bus.ex_ready}, 32'h0);
      @(posedge clk); #1;
    end
    bus.wb_ready = 1'b1;
    #1 chk("bp_release", {31'h0, bus.ex_ready}, 32'h1);
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_data", bus.wb_data, 32'hCAFE_0002);
    chk("bp_next_rd", {28'h0, bus.wb_rd}, 32'h6);

    // timeout, then a late ack must be ignored
    run_op(32'h0000_3000, 32'h0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, -1, 32'h5555_5555);
    bus.dmem_ack = 1'b1;
    @(posedge clk); #1 bus.dmem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", {31'h0, bus.dmem_req}, 32'h0);
    chk("late_ack_valid", {31'h0, bus.wb_valid}, 32'h0);
    chk("late_ack_ready", {31'h0, bus.ex_ready}, 32'h1);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 2);
      ld = (d == 1); st = (d == 2);
      run_op($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             ld, st, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1)), $urandom);
    end

    // reset in the middle of an access
    @(posedge clk); #1;
    bus.ex_valid = 1'b1; bus.ex_alu_result = 32'h0000_4000; bus.ex_is_load = 1'b1;
    bus.ex_is_store = 1'b0;
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    @(negedge clk);
    chk("mid_req_before", {31'h0, bus.dmem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_req_drop", {31'h0, bus.dmem_req}, 32'h0);
    chk("mid_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req", {31'h0, bus.dmem_req}, 32'h0);
    chk("post_rst_valid", {31'h0, bus.wb_valid}, 32'h0);
    chk("post_rst_ready", {31'h0, bus.ex_ready}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
